// File: rtl/iir_tdm_sched_pkg.sv
// iir_tdm_sched_pkg: shared FSM state type and width helper for the TDM biquad scheduler
package iir_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} sched_state_t;
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/iir_tdm_sched_if.sv
// iir_tdm_sched_if: scheduler <-> shared SOS engine handshake
//   master (scheduler): drives sos_start, sos_ch, sos_sec, sos_x; receives sos_done, sos_y
//   slave  (engine)   : the mirror image
interface iir_tdm_sched_if import iir_pkg::*; #(
   parameter int Ndint = 3,
   parameter int Ndfrac = 22,
   parameter int Nch = 4,
   parameter int Nsos = 3
);
   localparam int CHW = clog2_min1(Nch);
   localparam int SECW = clog2_min1(Nsos);
   logic                     sos_start;
   logic [CHW-1:0]           sos_ch;
   logic [SECW-1:0]          sos_sec;
   logic [Ndint-1:-Ndfrac]   sos_x;
   logic                     sos_done;
   logic [Ndint-1:-Ndfrac]   sos_y;
   modport master (output sos_start, sos_ch, sos_sec, sos_x, input sos_done, sos_y);
   modport slave (input sos_start, sos_ch, sos_sec, sos_x, output sos_done, sos_y);
endinterface

// File: rtl/iir_tdm_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requester at or after ptr (cyclic)
//   req       : per-channel request bits
//   ptr       : highest-priority channel this cycle
//   gnt_valid : any request present
//   gnt_idx   : granted channel
module rr_arbiter import iir_pkg::*; #(
   parameter int Nch = 4,
   localparam int CHW = clog2_min1(Nch)
) (
   input  logic [Nch-1:0] req,
   input  logic [CHW-1:0] ptr,
   output logic           gnt_valid,
   output logic [CHW-1:0] gnt_idx
);
   logic [CHW-1:0] w_j;
   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx = '0;
      w_j = '0;
      for (int i = Nch - 1; i >= 0; i--) begin
         w_j = CHW'((int'(ptr) + i) % Nch);
         if (req[w_j]) begin
            gnt_valid = 1'b1;
            gnt_idx = w_j;
         end
      end
   end
endmodule

// File: rtl/iir_tdm_sched.sv
// iir_tdm_sched: shares one SOS engine across Nch channels x Nsos cascaded sections, round-robin
//   clk, reset  : clock, synchronous active-high reset
//   dv_in, d_in : per-channel sample strobe and sample
//   sos         : engine handshake (iir_tdm_sched_if.master)
//   dv_out, ch_out, d_out : filtered sample strobe, its channel, sample (d_out/ch_out hold)
//   busy        : FSM not in IDLE
//   overrun     : sticky per-channel dropped-sample flags
//   timeout_err : sticky watchdog flag, only when IIR_SCHED_TIMEOUT_EN is defined (else 0)
module iir_tdm_sched import iir_pkg::*; #(
   parameter int Ndint = 3,
   parameter int Ndfrac = 22,
   parameter int Nch = 4,
   parameter int Nsos = 3,
   parameter int Timeout = 64,
   localparam int CHW = clog2_min1(Nch),
   localparam int SECW = clog2_min1(Nsos)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [Nch-1:0]                    dv_in,
   input  logic [Nch-1:0][Ndint-1:-Ndfrac]   d_in,
   iir_tdm_sched_if.master                   sos,
   output logic                              dv_out,
   output logic [CHW-1:0]                    ch_out,
   output logic [Ndint-1:-Ndfrac]            d_out,
   output logic                              busy,
   output logic [Nch-1:0]                    overrun,
   output logic                              timeout_err
);
   sched_state_t r_state, w_next;
   logic [Nch-1:0]                  r_pend, r_ovr, w_gc;
   logic [Nch-1:0][Ndint-1:-Ndfrac] r_hold;
   logic [CHW-1:0]                  r_ptr, w_gnt_idx, r_sos_ch, r_ch_out;
   logic [SECW-1:0]                 r_sos_sec;
   logic [Ndint-1:-Ndfrac]          r_sos_x, r_d_out;
   logic                            w_gnt_valid, w_grant, w_done, w_last, w_to;

   rr_arbiter #(.Nch(Nch)) u_arb (
      .req(r_pend), .ptr(r_ptr), .gnt_valid(w_gnt_valid), .gnt_idx(w_gnt_idx)
   );

   assign w_grant = (r_state == S_IDLE) && w_gnt_valid;
   assign w_gc = w_grant ? (Nch'(1) << w_gnt_idx) : '0;
   assign w_done = (r_state == S_WAIT) && sos.sos_done;
   assign w_last = r_sos_sec == SECW'(Nsos - 1);

`ifdef IIR_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(Timeout + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_to_err;
   assign w_to = (r_state == S_WAIT) && !sos.sos_done && (r_to_cnt == TW'(Timeout - 1));
   assign timeout_err = r_to_err;
   // Counter is zero whenever outside WAIT, so it restarts on every WAIT entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_to_cnt <= '0;
         r_to_err <= 1'b0;
      end else begin
         r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + 1'b1 : '0;
         if (w_to) r_to_err <= 1'b1;
      end
   end
`else
   assign w_to = 1'b0;
   // Keeps Timeout referenced when the watchdog is compiled out; always 0.
   assign timeout_err = Timeout < 0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = w_gnt_valid ? S_ISSUE : S_IDLE;
         S_ISSUE:  w_next = S_WAIT;
         S_WAIT:   w_next = sos.sos_done ? (w_last ? S_OUTPUT : S_ISSUE) : (w_to ? S_IDLE : S_WAIT);
         default:  w_next = S_IDLE;
      endcase
   end

   // sos_* registers double as the working sample and section counter; they load only on
   // entry to ISSUE, so they hold steady between passes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr <= '0;
         r_pend <= '0;
         r_ovr <= '0;
         r_sos_x <= '0;
         r_sos_ch <= '0;
         r_sos_sec <= '0;
         r_d_out <= '0;
         r_ch_out <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_ptr <= (w_gnt_idx == CHW'(Nch - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_sos_x <= r_hold[w_gnt_idx];
            r_sos_ch <= w_gnt_idx;
            r_sos_sec <= '0;
         end
         if (w_done) begin
            if (w_last) begin
               r_d_out <= sos.sos_y;
               r_ch_out <= r_sos_ch;
            end else begin
               r_sos_x <= sos.sos_y;
               r_sos_sec <= r_sos_sec + 1'b1;
            end
         end
         // A grant frees the holding register this cycle, so a same-cycle sample is kept.
         for (int c = 0; c < Nch; c++) begin
            if (dv_in[c] && (!r_pend[c] || w_gc[c])) begin
               r_hold[c] <= d_in[c];
               r_pend[c] <= 1'b1;
            end else if (w_gc[c]) begin
               r_pend[c] <= 1'b0;
            end
            if (dv_in[c] && r_pend[c] && !w_gc[c]) r_ovr[c] <= 1'b1;
         end
      end
   end

   assign sos.sos_start = r_state == S_ISSUE;
   assign sos.sos_x = r_sos_x;
   assign sos.sos_ch = r_sos_ch;
   assign sos.sos_sec = r_sos_sec;
   assign dv_out = r_state == S_OUTPUT;
   assign d_out = r_d_out;
   assign ch_out = r_ch_out;
   assign busy = r_state != S_IDLE;
   assign overrun = r_ovr;
endmodule

// File: tb/tb_iir_tdm_sched.sv
// tb_iir_tdm_sched: scoreboard bench for iir_tdm_sched with a +1 LSB engine of latency 4
module tb_iir_tdm_sched;
   localparam int L = 4;
   localparam int P = 17;
   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [3:0]      dv_in = '0;
   logic [3:0][2:-22] d_in = '0;
   logic            dv_out, busy, timeout_err;
   logic [1:0]      ch_out;
   logic [2:-22]    d_out;
   logic [3:0]      overrun;
   int              cyc = 0, n_chk = 0, n_err = 0, starts = 0, dv_cnt = 0, exp_sec = 0;
   int              eng_cnt = 0;
   logic [24:0]     eng_x = '0;
   logic            eng_on = 1'b1;

   typedef struct {int ch; logic [24:0] x; int cyc;} ent_t;
   ent_t sb[$];

   iir_tdm_sched_if #(.Ndint(3), .Ndfrac(22), .Nch(4), .Nsos(3)) sos_bus ();

   iir_tdm_sched #(.Ndint(3), .Ndfrac(22), .Nch(4), .Nsos(3), .Timeout(64)) dut (
      .clk(clk), .reset(reset), .dv_in(dv_in), .d_in(d_in), .sos(sos_bus),
      .dv_out(dv_out), .ch_out(ch_out), .d_out(d_out), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   initial begin
      sos_bus.sos_done = 1'b0;
      sos_bus.sos_y = '0;
   end

   // Engine: result L cycles after the start pulse, held for one cycle.
   always @(negedge clk) begin
      sos_bus.sos_done = 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0 && eng_on) begin
            sos_bus.sos_done = 1'b1;
            sos_bus.sos_y = eng_x + 25'd1;
         end
      end
      if (sos_bus.sos_start) begin
         eng_x = sos_bus.sos_x;
         eng_cnt = L;
      end
   end

   always @(negedge clk) begin
      if (reset || !busy) exp_sec = 0;
      if (sos_bus.sos_start) begin
         starts++;
         if (sb.size() != 0) begin
            check("start_ch", 32'(sos_bus.sos_ch), 32'(sb[0].ch));
            check("start_sec", 32'(sos_bus.sos_sec), 32'(exp_sec));
            check("start_x", 32'(sos_bus.sos_x), 32'(sb[0].x + 25'(exp_sec)));
         end
         exp_sec = (exp_sec == 2) ? 0 : exp_sec + 1;
      end
      if (dv_out) begin
         dv_cnt++;
         if (sb.size() == 0) check("dv_unexpected", 32'(1), 32'(0));
         else begin
            check("out_ch", 32'(ch_out), 32'(sb[0].ch));
            check("out_d", 32'(d_out), 32'(sb[0].x + 25'd3));
            check("out_cyc", 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_budget", 32'(n < budget), 32'(1));
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_zero(input string p);
      check({p, "_start"}, 32'(sos_bus.sos_start), 0);
      check({p, "_sos_ch"}, 32'(sos_bus.sos_ch), 0);
      check({p, "_sos_sec"}, 32'(sos_bus.sos_sec), 0);
      check({p, "_sos_x"}, 32'(sos_bus.sos_x), 0);
      check({p, "_dv_out"}, 32'(dv_out), 0);
      check({p, "_ch_out"}, 32'(ch_out), 0);
      check({p, "_d_out"}, 32'(d_out), 0);
      check({p, "_busy"}, 32'(busy), 0);
      check({p, "_overrun"}, 32'(overrun), 0);
      check({p, "_timeout"}, 32'(timeout_err), 0);
   endtask

   task automatic push(input int ch, input logic [24:0] x, input int c);
      ent_t e;
      e.ch = ch;
      e.x = x;
      e.cyc = c;
      sb.push_back(e);
   endtask

   initial begin
      int t0, s0, d0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      // Single sample on ch2.
      do_reset();
      @(negedge clk);
      t0 = cyc;
      s0 = starts;
      d_in[2] = 25'h000100;
      dv_in = 4'b0100;
      push(2, 25'h000100, t0 + P);
      @(negedge clk);
      dv_in = '0;
      wait_idle(100);
      check("single_starts", 32'(starts - s0), 32'd3);
      repeat (3) @(negedge clk);
      check("hold_d_out", 32'(d_out), 32'h000103);
      check("hold_ch_out", 32'(ch_out), 32'd2);
      check("hold_sos_x", 32'(sos_bus.sos_x), 32'h000102);
      check("hold_sos_sec", 32'(sos_bus.sos_sec), 32'd2);
      // All four channels at once: served in order, one per period.
      do_reset();
      @(negedge clk);
      t0 = cyc;
      for (int c = 0; c < 4; c++) begin
         d_in[c] = 25'(32'h1000 * (c + 1) + c);
         push(c, 25'(32'h1000 * (c + 1) + c), t0 + P * (c + 1));
      end
      dv_in = 4'b1111;
      @(negedge clk);
      dv_in = '0;
      wait_idle(200);
      check("all_overrun", 32'(overrun), 32'd0);
      // Second ch1 sample while ch1 still pending: dropped, flagged.
      do_reset();
      @(negedge clk);
      t0 = cyc;
      d_in[0] = 25'h1abcde;
      d_in[1] = 25'h0f0f0f;
      dv_in = 4'b0011;
      push(0, 25'h1abcde, t0 + P);
      push(1, 25'h0f0f0f, t0 + 2 * P);
      @(negedge clk);
      dv_in = '0;
      wait_until(t0 + 3);
      d_in[1] = 25'h055555;
      dv_in = 4'b0010;
      @(negedge clk);
      dv_in = '0;
      check("ovr_flag_early", 32'(overrun), 32'b0010);
      wait_idle(200);
      check("ovr_flag", 32'(overrun), 32'b0010);
      // Same-channel sample in its own grant cycle: kept, no overrun.
      do_reset();
      @(negedge clk);
      t0 = cyc;
      d0 = dv_cnt;
      d_in[0] = 25'h000777;
      dv_in = 4'b0001;
      push(0, 25'h000777, t0 + P);
      @(negedge clk);
      d_in[0] = 25'h1ffff0;
      push(0, 25'h1ffff0, t0 + 2 * P);
      @(negedge clk);
      dv_in = '0;
      wait_idle(200);
      check("grant_ovr", 32'(overrun), 32'd0);
      check("grant_outputs", 32'(dv_cnt - d0), 32'd2);
      // Reset in WAIT of section 1.
      do_reset();
      @(negedge clk);
      t0 = cyc;
      d0 = dv_cnt;
      d_in[3] = 25'h012345;
      dv_in = 4'b1000;
      push(3, 25'h012345, t0 + P);
      @(negedge clk);
      dv_in = '0;
      wait_until(t0 + 9);
      check("rst_pre_busy", 32'(busy), 32'd1);
      check("rst_pre_sec", 32'(sos_bus.sos_sec), 32'd1);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check_zero("rst_wait");
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_no_dv", 32'(dv_cnt - d0), 32'd0);
      check("rst_idle", 32'(busy), 32'd0);
`ifdef IIR_SCHED_TIMEOUT_EN
      // Engine silent: watchdog fires 64 cycles after entering WAIT.
      do_reset();
      eng_on = 1'b0;
      @(negedge clk);
      t0 = cyc;
      d0 = dv_cnt;
      d_in[1] = 25'h000042;
      dv_in = 4'b0010;
      @(negedge clk);
      dv_in = '0;
      wait_until(t0 + 66);
      check("to_before", 32'(timeout_err), 32'd0);
      check("to_busy_before", 32'(busy), 32'd1);
      @(negedge clk);
      check("to_after", 32'(timeout_err), 32'd1);
      check("to_idle", 32'(busy), 32'd0);
      check("to_no_dv", 32'(dv_cnt - d0), 32'd0);
      eng_on = 1'b1;
      @(negedge clk);
      t0 = cyc;
      d_in[2] = 25'h000200;
      dv_in = 4'b0100;
      push(2, 25'h000200, t0 + P);
      @(negedge clk);
      dv_in = '0;
      wait_idle(100);
      check("to_sticky", 32'(timeout_err), 32'd1);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end
endmodule

// File: doc/iir_tdm_sched.md
# iir_tdm_sched

Time-division scheduler that shares one external second-order-section (SOS) compute engine across `Nch` independent input channels and `Nsos` cascaded sections. It captures per-channel samples and picks channels round-robin. For each sample it issues `Nsos` back-to-back section passes to the engine, feeding each section's result into the next. It emits the fully filtered sample tagged with its channel. It sits between the channel sample sources and a single shared biquad engine, and replaces one hardware cascade per channel.

## Interface
Parameters:
- `Ndint`, 3: integer bits of sample format (signed fixed point `[Ndint-1:-Ndfrac]`)
- `Ndfrac`, 22: fractional bits of sample format
- `Nch`, 4: number of channels, ≥1
- `Nsos`, 3: sections per cascade, ≥1
- `Timeout`, 64: watchdog limit in cycles; used only when `IIR_SCHED_TIMEOUT_EN` is defined

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `dv_in`  in  `Nch`  per-channel sample strobe
- `d_in`  in  `Nch` × `[Ndint-1:-Ndfrac]`  per-channel sample
- `sos_start`  out  1  one-cycle pulse that launches an engine pass
- `sos_ch`  out  `$clog2(Nch)` (min 1)  channel for state/coeff selection
- `sos_sec`  out  `$clog2(Nsos)` (min 1)  section index
- `sos_x`  out  `[Ndint-1:-Ndfrac]`  section input
- `sos_done`  in  1  engine result strobe
- `sos_y`  in  `[Ndint-1:-Ndfrac]`  section result
- `dv_out`  out  1  filtered sample strobe
- `ch_out`  out  `$clog2(Nch)`  channel of `d_out`
- `d_out`  out  `[Ndint-1:-Ndfrac]`  filtered sample
- `busy`  out  1  high when not in IDLE
- `overrun`  out  `Nch`  sticky per-channel dropped-sample flags
- `timeout_err`  out  1  sticky watchdog flag; tied 0 when feature is compiled out

## Operation
- Each channel has a holding register and a `pending` bit. `dv_in[c]` with `pending[c]=0` loads the register and sets `pending`.
- `dv_in[c]` with `pending[c]=1` drops the new sample and sets `overrun[c]`. The exception is a grant to channel `c` in the same cycle: then the new sample loads and `pending` stays 1.
- FSM states are IDLE, ISSUE, WAIT and OUTPUT.
  - IDLE: if any `pending`, grant the lowest channel at or after `rr_ptr`, cyclically. Copy its register to the working register `w`, clear its `pending`, set `sec=0`, set `rr_ptr=grant+1` (mod `Nch`), then go to ISSUE.
  - ISSUE: assert `sos_start` for one cycle with `sos_x=w`, `sos_sec=sec` and `sos_ch` set to the granted channel. Then go to WAIT.
  - WAIT: on `sos_done`, set `w=sos_y`. If `sec==Nsos-1`, go to OUTPUT; otherwise increment `sec` and go to ISSUE.
  - OUTPUT: drive `dv_out=1`, `d_out=w` and `ch_out` set to the granted channel for one cycle, then go to IDLE.
- `sos_done` is ignored outside WAIT.
- `sos_x`, `sos_ch` and `sos_sec` hold their values until the next ISSUE.
- `d_out` holds its value after the `dv_out` pulse.
- No arithmetic is done here: samples pass through bit-exact.

## Timing
- Reset values: FSM=IDLE, `rr_ptr=0`, all `pending=0`. All outputs are 0: `sos_start`, `sos_ch`, `sos_sec`, `sos_x`, `dv_out`, `ch_out`, `d_out`, `busy`, `overrun`, `timeout_err`.
- Reset during any state aborts the pass in flight with no `dv_out`. Subsequent `sos_done` pulses from the engine are ignored, because the FSM is in IDLE.
- Latency with the engine's done `L`≥1 cycles after start, idle scheduler, `dv_in` at cycle 0:
  - `pending` is visible at cycle 1, and the grant happens at cycle 1.
  - Section k starts at cycle 2+k(L+1).
  - `dv_out` is at cycle 2+Nsos(L+1), for example 17 for `Nsos=3`, `L=4`.
- Sustained throughput: one sample every Nsos(L+1)+2 cycles, shared across all channels.

## Configuration
- `IIR_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `Timeout` cycles elapse without `sos_done`, the block sets `timeout_err` (sticky until reset), discards the sample (no `dv_out`) and returns to IDLE.
  - The counter clears on each entry to WAIT.
- Undefined: no counter, `timeout_err` is tied to 0, and WAIT waits indefinitely.

## Structure
- Package `iir_pkg`:
  - FSM state enum `sched_state_t`.
  - Helper function `clog2_min1`.
- Sub-module `rr_arbiter`, parameterized by `Nch`: inputs `req[Nch]`, `ptr`; outputs `gnt_valid`, `gnt_idx`; purely combinational.

## Test plan
Bench engine model: `sos_y = sos_x + 1 LSB`, `L=4`, `Nch=4`, `Nsos=3`.
- Single sample 0x000100 on ch2 at cycle 0 → three `sos_start` pulses with `sec` 0,1,2 and `sos_ch=2`; `dv_out` at cycle 17 with `ch_out=2`, `d_out=0x000103`.
- Simultaneous `dv_in` on ch0–ch3 → outputs in channel order 0,1,2,3, 17 cycles apart (first at 17), none of `overrun` set.
- Second `dv_in` on ch1 while ch1 is pending and not yet granted → `overrun[1]=1`, only the first sample is output.
- `dv_in` on ch0 in the grant cycle of ch0 → both samples are output, `overrun[0]=0`.
- Reset asserted in WAIT of section 1 → all outputs are 0 the next cycle, a late `sos_done` is ignored, no `dv_out`.
- With `IIR_SCHED_TIMEOUT_EN`, `Timeout=64`: engine never responds → `timeout_err=1` 64 cycles after entering WAIT, FSM returns to IDLE, and the next sample on another channel completes normally.
